// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back data cache between the CPU datapath and a word-wide data memory.
// Load hits return data combinationally; misses walk WRITEBACK -> FETCH -> UPDATE.
module dcache_ctrl #(
  parameter int NBLOCKS     = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic [1:0]  o_dbg_state
);

  localparam int IDX_W = $clog2(NBLOCKS);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = 8 - IDX_W - OFF_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FETCH     = 2'd2;
  localparam logic [1:0] S_UPDATE    = 2'd3;

  // Handshake: the CPU holds READ/WRITE, ADDRESS and WRITEDATA until it sees
  // BUSYWAIT low; a memory request completes in the cycle MEM_BUSYWAIT is low.

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [31:0]      r_data [NBLOCKS];
  logic [TAG_W-1:0] r_tag  [NBLOCKS];
  logic [NBLOCKS-1:0] r_valid;
  logic [NBLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0] r_miss_tag;
  logic [IDX_W-1:0] r_miss_idx;
  logic [31:0]      r_fill;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic [OFF_W+2:0] w_byte_sel;
  logic [31:0]      w_line;
  logic             w_hit;
  logic             w_req;
  logic             w_idle_miss;
  logic             w_store;

  assign w_tag       = ADDRESS[7:IDX_W+OFF_W];
  assign w_idx       = ADDRESS[IDX_W+OFF_W-1:OFF_W];
  assign w_off       = ADDRESS[OFF_W-1:0];
  assign w_byte_sel  = {w_off, 3'b000};
  assign w_line      = r_data[w_idx];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_req       = READ || WRITE;
  assign w_idle_miss = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_store     = (r_state == S_IDLE) && WRITE && w_hit;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_idle_miss) begin
          w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: if (!MEM_BUSYWAIT) w_state_nxt = S_FETCH;
      S_FETCH:     if (!MEM_BUSYWAIT) w_state_nxt = S_UPDATE;
      S_UPDATE:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Miss states address the latched victim/target so a dropped request still completes cleanly.
  always_comb begin
    READDATA      = 8'h00;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    case (r_state)
      S_IDLE: begin
        BUSYWAIT = w_req && !w_hit;
        if (READ && w_hit) READDATA = w_line[w_byte_sel +: 8];
      end
      S_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[r_miss_idx], r_miss_idx};
        MEM_WRITEDATA = r_data[r_miss_idx];
      end
      S_FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_miss_tag, r_miss_idx};
      end
      S_UPDATE: BUSYWAIT = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_store) r_dirty[w_idx] <= 1'b1;
      if (r_state == S_UPDATE) begin
        r_valid[r_miss_idx] <= 1'b1;
        r_dirty[r_miss_idx] <= 1'b0;
      end
    end
  end

  // Data, tags and the miss latch carry no reset; validity alone qualifies them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (w_idle_miss) begin
        r_miss_tag <= w_tag;
        r_miss_idx <= w_idx;
      end
      if ((r_state == S_FETCH) && !MEM_BUSYWAIT) r_fill <= MEM_READDATA;
      if (w_store) r_data[w_idx][w_byte_sel +: 8] <= WRITEDATA;
      if (r_state == S_UPDATE) begin
        r_data[r_miss_idx] <= r_fill;
        r_tag[r_miss_idx]  <= r_miss_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, reset-mid-fetch sequence,
// then random loads/stores against a byte-level memory view and a line-state model.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [1:0]  o_dbg_state;

  always #5 CLK = ~CLK;

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory model: busy for lat cycles of a request, completes on the next
  logic [31:0] mem   [64];
  logic [7:0]  truth [256];
  int lat  = 5;
  int mcnt = 0;
  int wb_count = 0, fetch_count = 0;
  logic [5:0]  last_wb_addr, last_fetch_addr;
  logic [31:0] last_wb_data;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < lat);
  assign MEM_READDATA = MEM_READ ? mem[MEM_ADDRESS] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] truth_block(input logic [5:0] b);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = truth[{b, 2'b00} + k];
    return w;
  endfunction

  task automatic truth_from_mem();
    for (int i = 0; i < 256; i++) truth[i] = mem[i >> 2][(i % 4) * 8 +: 8];
  endtask

  always @(posedge CLK) begin
    if (RESET) mcnt <= 0;
    else if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  always @(negedge CLK) begin
    if (!RESET && MEM_WRITE && !MEM_BUSYWAIT) begin
      wb_count++;
      last_wb_addr = MEM_ADDRESS;
      last_wb_data = MEM_WRITEDATA;
      check("wb_block", MEM_WRITEDATA, truth_block(MEM_ADDRESS));
      mem[MEM_ADDRESS] = MEM_WRITEDATA;
    end
    if (!RESET && MEM_READ && !MEM_BUSYWAIT) begin
      fetch_count++;
      last_fetch_addr = MEM_ADDRESS;
    end
  end

  // Called aligned #1 after a posedge; returns aligned the same way.
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       output int stall, output logic [7:0] rdat);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    stall = 0;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stall++;
      if (stall > 200) begin
        check("busywait_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    rdat = READDATA;
    @(posedge CLK); #1;
    if (wr) truth[a] = wd;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    int         exp_stall;
    logic       chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tab[13];

  logic       m_valid [8];
  logic       m_dirty [8];
  logic [2:0] m_tag   [8];

  initial begin
    int         stall;
    logic [7:0] rdat;
    int         bound;

    // lat = 5: clean miss 1+6+1 = 8 stall cycles, dirty miss adds 6
    tab[0]  = '{"rd00_miss",      1, 0, 8'h00, 8'h00, 8,  1, 8'h11};
    tab[1]  = '{"rd03_hit",       1, 0, 8'h03, 8'h00, 0,  1, 8'h44};
    tab[2]  = '{"wr02_hit",       0, 1, 8'h02, 8'hAA, 0,  0, 8'h00};
    tab[3]  = '{"rd02_after_wr",  1, 0, 8'h02, 8'h00, 0,  1, 8'hAA};
    tab[4]  = '{"rd22_dirty",     1, 0, 8'h22, 8'h00, 14, 1, 8'h77};
    tab[5]  = '{"wr15_miss",      0, 1, 8'h15, 8'h7F, 8,  0, 8'h00};
    tab[6]  = '{"rd15_hit",       1, 0, 8'h15, 8'h00, 0,  1, 8'h7F};
    tab[7]  = '{"rd14_hit",       1, 0, 8'h14, 8'h00, 0,  1, 8'h08};
    tab[8]  = '{"rd23_hit",       1, 0, 8'h23, 8'h00, 0,  1, 8'h88};
    tab[9]  = '{"rd02_refetch",   1, 0, 8'h02, 8'h00, 8,  1, 8'hAA};
    tab[10] = '{"rw01_store",     1, 1, 8'h01, 8'h5C, 0,  0, 8'h00};
    tab[11] = '{"rd01_after_rw",  1, 0, 8'h01, 8'h00, 0,  1, 8'h5C};
    tab[12] = '{"rd35_dirty",     1, 0, 8'h35, 8'h00, 14, 1, 8'hBE};

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[6'h00] = 32'h44332211;
    mem[6'h08] = 32'h88776655;
    mem[6'h05] = 32'h0B0A0908;
    mem[6'h0D] = 32'hDEADBEEF;
    truth_from_mem();

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_readdata", 32'(READDATA), 32'h0);
    check("rst_busywait", 32'(BUSYWAIT), 32'h0);
    check("rst_mem_read", 32'(MEM_READ), 32'h0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'h0);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
    check("rst_state_idle", 32'(o_dbg_state), 32'h0);
    @(posedge CLK); #1;

    for (int i = 0; i < 13; i++) begin
      do_op(tab[i].rd, tab[i].wr, tab[i].addr, tab[i].wd, stall, rdat);
      check({tab[i].name, "_stall"}, 32'(stall), 32'(tab[i].exp_stall));
      if (tab[i].chk_rd) check({tab[i].name, "_data"}, 32'(rdat), 32'(tab[i].exp_rd));
      if (i == 4) begin
        check("evict0_wb_addr", 32'(last_wb_addr), 32'h00);
        check("evict0_wb_data", last_wb_data, 32'h44AA2211);
        check("evict0_fetch_addr", 32'(last_fetch_addr), 32'h08);
        check("evict0_wb_count", 32'(wb_count), 32'd1);
      end
      if (i == 5) begin
        check("wr15_no_writeback", 32'(wb_count), 32'd1);
        check("wr15_fetch_addr", 32'(last_fetch_addr), 32'h05);
      end
      if (i == 12) begin
        check("evict5_wb_addr", 32'(last_wb_addr), 32'h05);
        check("evict5_wb_data", last_wb_data, 32'h0B0A7F08);
      end
    end

    // reset in the middle of a fetch abandons it and invalidates everything
    READ = 1'b1; ADDRESS = 8'h2C;
    bound = 0;
    do begin
      @(negedge CLK);
      bound++;
    end while (!MEM_READ && bound < 20);
    check("midfetch_reached", 32'(MEM_READ), 32'h1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLK);
    check("midfetch_rst_mem_read", 32'(MEM_READ), 32'h0);
    check("midfetch_rst_busywait", 32'(BUSYWAIT), 32'h0);
    check("midfetch_rst_state", 32'(o_dbg_state), 32'h0);
    @(posedge CLK); #1;
    truth_from_mem();
    do_op(1'b1, 1'b0, 8'h01, 8'h00, stall, rdat);
    check("post_rst_rd01_stall", 32'(stall), 32'd8);
    check("post_rst_rd01_data", 32'(rdat), 32'h22);

    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 3'd0;
    end
    m_valid[0] = 1'b1;

    for (int n = 0; n < 300; n++) begin
      logic       rd, wr;
      logic [7:0] a, wd;
      logic [2:0] tg, ix;
      int         kind, exp_stall;
      logic       hit;
      lat  = $urandom_range(1, 4);
      kind = $urandom_range(0, 3);
      rd   = (kind != 1);
      wr   = (kind == 1) || (kind == 2);
      tg   = 3'($urandom_range(0, 2));
      ix   = 3'($urandom_range(0, 7));
      a    = {tg, ix, 2'($urandom_range(0, 3))};
      wd   = 8'($urandom);
      hit  = m_valid[ix] && (m_tag[ix] == tg);
      if (hit) exp_stall = 0;
      else if (m_valid[ix] && m_dirty[ix]) exp_stall = 2 * (lat + 1) + 2;
      else exp_stall = lat + 3;
      if (rd && !wr) begin
        logic [7:0] exp_byte;
        exp_byte = truth[a];
        do_op(rd, wr, a, wd, stall, rdat);
        check("rand_load_data", 32'(rdat), 32'(exp_byte));
      end else begin
        do_op(rd, wr, a, wd, stall, rdat);
      end
      check("rand_stall", 32'(stall), 32'(exp_stall));
      if (!hit) begin
        m_valid[ix] = 1'b1; m_tag[ix] = tg; m_dirty[ix] = 1'b0;
      end
      if (wr) m_dirty[ix] = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
